// File: rtl/add_stg_out_buffer.sv
// Output buffer behind the mult-unit adder stage: a FWFT FIFO of valid words with a run/flush/drain sequencer.
// Optional row-order monitor enabled by defining ROW_ORDER_CHECK_EN.

`ifndef DATA_WIDTH_ADD_STG
`define DATA_WIDTH_ADD_STG 24
`endif
`ifndef BITS_ROW_IDX
`define BITS_ROW_IDX 8
`endif

module add_stg_out_buffer #(
    parameter int DATA_WIDTH   = `DATA_WIDTH_ADD_STG,
    parameter int BITS_ROW_IDX = `BITS_ROW_IDX,
    parameter int DEPTH        = 16,
    parameter int AF_MARGIN    = 3,
    parameter int FLUSH_CYCLES = 4,
    localparam int CW          = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_ended,
    input  logic                  deq,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  out_valid,
    output logic                  almost_full,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  drain_done
`ifdef ROW_ORDER_CHECK_EN
    ,
    output logic                  row_order_err
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0] AF_THRESH  = CW'(DEPTH - AF_MARGIN);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_FLUSH, S_DRAIN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [FW-1:0]         flush_cnt_q, flush_cnt_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic accepting, start_ok, deq_fire, enq_fire, drop;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        overflow_d  = overflow_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        accepting = (state_q == S_RUN) || (state_q == S_FLUSH);
        start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
        deq_fire  = deq && out_valid_q;
        enq_fire  = accepting && data_in[0] && ((count_q != DEPTH_C) || deq_fire);
        drop      = accepting && data_in[0] && !enq_fire;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    state_d    = S_RUN;
                    overflow_d = 1'b0;
                end
            end
            S_RUN: begin
                if (data_ended) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = FLUSH_LAST;
                end
            end
            S_FLUSH: begin
                if (flush_cnt_q == '0) state_d = S_DRAIN;
                else                   flush_cnt_d = flush_cnt_q - FW'(1);
            end
            S_DRAIN: begin
                if (count_q == '0) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        if (drop) overflow_d = 1'b1;

        if (enq_fire) wr_ptr_d = wr_ptr_q + PW'(1);
        if (deq_fire) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({enq_fire, deq_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // The next head is the incoming word when it lands exactly where the read pointer will point.
        out_valid_d = (count_d != '0);
        data_out_d  = (enq_fire && (wr_ptr_q == rd_ptr_d)) ? data_in : mem[rd_ptr_d];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            flush_cnt_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
        end
    end

    // NOTE: storage is deliberately left unreset; occupancy and out_valid already mask stale entries.
    always_ff @(posedge clk) begin
        if (enq_fire) mem[wr_ptr_q] <= data_in;
    end

`ifdef ROW_ORDER_CHECK_EN
    logic [BITS_ROW_IDX-1:0] row_in, prev_row_q, prev_row_d;
    logic                    have_prev_q, have_prev_d, row_err_q, row_err_d;

    always_comb begin
        row_in      = data_in[DATA_WIDTH-1 -: BITS_ROW_IDX];
        prev_row_d  = prev_row_q;
        have_prev_d = have_prev_q;
        row_err_d   = row_err_q;
        if (start_ok) begin
            have_prev_d = 1'b0;
            row_err_d   = 1'b0;
        end else if (enq_fire) begin
            if (have_prev_q && (row_in <= prev_row_q)) row_err_d = 1'b1;
            prev_row_d  = row_in;
            have_prev_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_row_q  <= '0;
            have_prev_q <= 1'b0;
            row_err_q   <= 1'b0;
        end else begin
            prev_row_q  <= prev_row_d;
            have_prev_q <= have_prev_d;
            row_err_q   <= row_err_d;
        end
    end

    assign row_order_err = row_err_q;
`endif

    assign data_out    = data_out_q;
    assign out_valid   = out_valid_q;
    assign count       = count_q;
    assign almost_full = (count_q >= AF_THRESH);
    assign overflow    = overflow_q;
    assign drain_done  = (state_q == S_DONE);

endmodule
